emg_duty_controller: RTL and testbench
======================================

Name: emg_duty_controller

Overview:
- Upstream stage of the servo PWM generator.
- Converts raw EMG ADC samples into a smoothed envelope, then runs a debounced grip state machine.
- Produces a slew-limited servo duty value in clock counts, plus a once-per-frame enable pulse and a one-shot start tick for the PWM stage.
- Sits between the ADC sampler and the PWM generator.

Parameters:
- PERIOD, 1000000: servo frame length in clocks (50 Hz at 50 MHz).
- DBIT, 20: duty width.
- SBIT, 12: ADC sample width.
- MID, 2048: ADC zero-signal midscale.
- K, 4: envelope filter shift; smoothing factor 2^-K.
- TH_HI, 400: envelope close threshold.
- TH_LO, 200: envelope open threshold. TH_LO < TH_HI.
- HOLD_FRAMES, 3: consecutive frames beyond a threshold required before a transition.
- DUTY_OPEN, 50000: duty for hand open (1 ms).
- DUTY_CLOSED, 100000: duty for hand closed (2 ms).
- STEP, 1000: maximum duty change per frame.
- STARTUP_FRAMES, 5: frames after reset before big_tick fires.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- sample_valid, input, 1: one-cycle strobe; sample is valid.
- sample, input, SBIT: unsigned ADC sample.
- big_tick, output, 1: one-cycle start pulse to the PWM stage.
- en, output, 1: one-cycle frame pulse to the PWM stage.
- duty, output, DBIT: servo high-time in clocks.
- grip_state, output, 2: 00 OPEN, 01 CLOSING, 10 CLOSED, 11 OPENING.
- envelope, output, SBIT: current filtered envelope.

Behaviour:
- Reset (reset=0, asynchronous): frame counter=0, startup counter=0, envelope=0, duty=DUTY_OPEN, grip_state=OPEN, both hold counters=0, en=0, big_tick=0. Asserting reset mid-operation aborts everything and restarts the startup sequence.
- Frame counter:
  - Counts 0..PERIOD-1 and wraps.
  - "Frame end" is the cycle where counter==PERIOD-1.
  - "Eval cycle" is the cycle where counter==0.
- Startup:
  - big_tick pulses high for exactly one cycle at the frame end of frame number STARTUP_FRAMES (first frame = 1).
  - It never pulses again until the next reset.
- en:
  - Pulses for one cycle at every frame end strictly after the big_tick frame.
  - en is never coincident with big_tick.
- Rectifier:
  - rect = sample-MID if sample>=MID, else MID-sample.
  - Unsigned, SBIT bits.
- Envelope filter:
  - Updates only on cycles with sample_valid=1.
  - env <= env + ((rect - env) >>> K), using signed SBIT+1 arithmetic with arithmetic right shift; the result is truncated to SBIT.
  - Fixed-point residue is permitted: env may settle up to 2^K-1 below rect.
  - If sample_valid=0, env holds.
- Hold counters:
  - Evaluated only on eval cycles, using the env value registered before that edge. A simultaneous sample_valid update is seen next frame.
  - hi_cnt increments if env>TH_HI, otherwise clears.
  - lo_cnt increments if env<TH_LO, otherwise clears.
  - Both saturate at HOLD_FRAMES.
- Grip FSM (eval cycles only; all counter comparisons use the pre-increment value plus the current frame):
  - OPEN: if hi_cnt reaches HOLD_FRAMES, go to CLOSING.
  - CLOSING:
    - If lo_cnt reaches HOLD_FRAMES, go to OPENING.
    - Otherwise duty = min(duty+STEP, DUTY_CLOSED). When the result equals DUTY_CLOSED, go to CLOSED.
  - CLOSED: if lo_cnt reaches HOLD_FRAMES, go to OPENING.
  - OPENING:
    - If hi_cnt reaches HOLD_FRAMES, go to CLOSING.
    - Otherwise duty = max(duty-STEP, DUTY_OPEN). When the result equals DUTY_OPEN, go to OPEN.
  - On entry to CLOSING or OPENING, the first slew step happens on the following eval cycle.
- Duty arithmetic:
  - Computed in DBIT+1 bits so the sum never wraps.
  - Clamped to [DUTY_OPEN, DUTY_CLOSED].
  - duty changes only on the edge ending an eval cycle, so it is stable for PERIOD-1 cycles before every en.
- Hold counters clear on every state transition.

Test Plan (PERIOD=100, STARTUP_FRAMES=2, HOLD_FRAMES=2, STEP=20000, K=2, TH_HI=400, TH_LO=200, other parameters at default):
- Reset release at cycle 0: big_tick single pulse at cycle 199; en pulses at cycles 299, 399, 499…; no en before 299; duty=50000 throughout.
- sample=2048 with sample_valid every cycle: envelope stays 0; grip_state stays OPEN; duty stays 50000.
- sample=3048 with sample_valid every cycle:
  - envelope rises 250, 437, … and settles at 997.
  - After 2 eval cycles with env>400, grip_state becomes CLOSING.
  - Duty then steps 70000, 90000, 100000 on successive eval cycles, and grip_state becomes CLOSED with the 100000 step.
- From CLOSED, drive sample=2048:
  - envelope decays below 200.
  - After 2 eval cycles below threshold, grip_state becomes OPENING.
  - Duty then steps 80000, 60000, 50000, ending in OPEN.
- Glitch: env>400 for exactly one eval cycle, then 300 → no transition; hi_cnt returns to 0.
- Reset asserted mid-CLOSING at duty=70000 → immediately duty=50000, grip_state=OPEN, en=0, envelope=0; after release, big_tick reappears 200 cycles later.

Source files
------------

// File: rtl/emg_duty_controller.sv
// emg_duty_controller: EMG envelope -> debounced grip FSM -> slew-limited servo duty, with frame/start pulses.
// Ports: clk, reset (async, active-low); sample_valid/sample: ADC input strobe and value;
//        big_tick: one-shot PWM start; en: per-frame pulse; duty: servo high-time in clocks;
//        grip_state: 00 OPEN, 01 CLOSING, 10 CLOSED, 11 OPENING; envelope: filtered |sample-MID|.
module emg_duty_controller #(
  parameter int PERIOD         = 1000000,
  parameter int DBIT           = 20,
  parameter int SBIT           = 12,
  parameter int MID            = 2048,
  parameter int K              = 4,
  parameter int TH_HI          = 400,
  parameter int TH_LO          = 200,
  parameter int HOLD_FRAMES    = 3,
  parameter int DUTY_OPEN      = 50000,
  parameter int DUTY_CLOSED    = 100000,
  parameter int STEP           = 1000,
  parameter int STARTUP_FRAMES = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sample_valid,
  input  logic [SBIT-1:0] sample,
  output logic            big_tick,
  output logic            en,
  output logic [DBIT-1:0] duty,
  output logic [1:0]      grip_state,
  output logic [SBIT-1:0] envelope
);
  typedef enum logic [1:0] {OPEN = 2'b00, CLOSING = 2'b01, CLOSED = 2'b10, OPENING = 2'b11} grip_t;
  localparam int CW = PERIOD > 1 ? $clog2(PERIOD) : 1;
  localparam int UW = $clog2(STARTUP_FRAMES + 1);
  localparam int HW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CW-1:0]   LAST     = CW'(PERIOD - 1);
  localparam logic [UW-1:0]   SU       = UW'(STARTUP_FRAMES);
  localparam logic [HW-1:0]   HOLD     = HW'(HOLD_FRAMES);
  localparam logic [SBIT-1:0] MIDV     = SBIT'(MID);
  localparam logic [SBIT-1:0] THH      = SBIT'(TH_HI);
  localparam logic [SBIT-1:0] THL      = SBIT'(TH_LO);
  localparam logic [DBIT:0]   D_OPEN   = (DBIT+1)'(DUTY_OPEN);
  localparam logic [DBIT:0]   D_CLOSED = (DBIT+1)'(DUTY_CLOSED);
  localparam logic [DBIT:0]   D_STEP   = (DBIT+1)'(STEP);
  localparam logic [DBIT:0]   D_LOW    = (DBIT+1)'(DUTY_OPEN + STEP);
  logic [CW-1:0]        cnt;
  logic [UW-1:0]        su_cnt;
  logic [HW-1:0]        hi_cnt, lo_cnt, hi_nxt, lo_nxt, hi_inc, lo_inc;
  grip_t                state, state_nxt;
  logic [DBIT-1:0]      duty_nxt;
  logic [DBIT:0]        up_c, dn_c;
  logic [SBIT-1:0]      rect, env_nxt;
  logic signed [SBIT:0] diff, step_v;
  logic                 frame_end, eval, above, below, hi_hit, lo_hit;
  assign frame_end  = cnt == LAST;
  assign eval       = cnt == '0;
  // su_cnt counts completed frames and parks at STARTUP_FRAMES, so big_tick fires once per reset
  assign big_tick   = frame_end && su_cnt == SU - 1'b1;
  assign en         = frame_end && su_cnt == SU;
  assign grip_state = state;
  assign rect    = sample >= MIDV ? sample - MIDV : MIDV - sample;
  assign diff    = $signed({1'b0, rect}) - $signed({1'b0, envelope});
  assign step_v  = diff >>> K;
  assign env_nxt = envelope + step_v[SBIT-1:0];
  assign above  = envelope > THH;
  assign below  = envelope < THL;
  assign hi_inc = !above ? '0 : hi_cnt == HOLD ? hi_cnt : hi_cnt + 1'b1;
  assign lo_inc = !below ? '0 : lo_cnt == HOLD ? lo_cnt : lo_cnt + 1'b1;
  // "reaches HOLD" counts the current frame on top of the stored run length
  assign hi_hit = above && hi_cnt >= HOLD - 1'b1;
  assign lo_hit = below && lo_cnt >= HOLD - 1'b1;
  // one bit of headroom keeps the up-step from wrapping; the down-step is clamped before subtracting
  assign up_c = {1'b0, duty} + D_STEP > D_CLOSED ? D_CLOSED : {1'b0, duty} + D_STEP;
  assign dn_c = {1'b0, duty} < D_LOW ? D_OPEN : {1'b0, duty} - D_STEP;
  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    hi_nxt    = hi_cnt;
    lo_nxt    = lo_cnt;
    if (eval) begin
      hi_nxt = hi_inc;
      lo_nxt = lo_inc;
      case (state)
        OPEN:    state_nxt = hi_hit ? CLOSING : OPEN;
        CLOSED:  state_nxt = lo_hit ? OPENING : CLOSED;
        CLOSING: begin
          duty_nxt  = lo_hit ? duty : up_c[DBIT-1:0];
          state_nxt = lo_hit ? OPENING : up_c == D_CLOSED ? CLOSED : CLOSING;
        end
        OPENING: begin
          duty_nxt  = hi_hit ? duty : dn_c[DBIT-1:0];
          state_nxt = hi_hit ? CLOSING : dn_c == D_OPEN ? OPEN : OPENING;
        end
        default: state_nxt = OPEN;
      endcase
      if (state_nxt != state) begin
        hi_nxt = '0;
        lo_nxt = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      su_cnt   <= '0;
      envelope <= '0;
      duty     <= D_OPEN[DBIT-1:0];
      state    <= OPEN;
      hi_cnt   <= '0;
      lo_cnt   <= '0;
    end else begin
      cnt      <= frame_end ? '0 : cnt + 1'b1;
      su_cnt   <= frame_end && su_cnt != SU ? su_cnt + 1'b1 : su_cnt;
      envelope <= sample_valid ? env_nxt : envelope;
      duty     <= duty_nxt;
      state    <= state_nxt;
      hi_cnt   <= hi_nxt;
      lo_cnt   <= lo_nxt;
    end
  end
endmodule

// File: tb/tb_emg_duty_controller.sv
// tb_emg_duty_controller: scoreboarded directed test of the EMG duty controller.
module tb_emg_duty_controller;
  typedef struct {
    bit         big;
    int         cyc;
    int         duty;
    logic [1:0] st;
    int         env;
  } exp_t;
  localparam logic [1:0] S_OPEN = 2'b00, S_CLOSING = 2'b01, S_CLOSED = 2'b10, S_OPENING = 2'b11;
  logic        clk = 0;
  logic        reset;
  logic        sample_valid;
  logic [11:0] sample;
  logic        big_tick, en;
  logic [19:0] duty;
  logic [1:0]  grip_state;
  logic [11:0] envelope;
  int          cyc;
  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];
  exp_t        e;
  emg_duty_controller #(
    .PERIOD(100), .STARTUP_FRAMES(2), .HOLD_FRAMES(2), .STEP(20000), .K(2),
    .TH_HI(400), .TH_LO(200)
  ) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
    .big_tick(big_tick), .en(en), .duty(duty), .grip_state(grip_state), .envelope(envelope)
  );
  always #5 clk = ~clk;
  // cycle index since reset release; equals the DUT frame counter position
  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic check(string n, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic push(bit b, int c, int d, logic [1:0] s, int v);
    exp_t x;
    x.big = b; x.cyc = c; x.duty = d; x.st = s; x.env = v;
    sb.push_back(x);
  endtask
  task automatic at_cycle(int c);
    while (cyc < c) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (reset && (en || big_tick)) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL pulse: unexpected en=%0b big_tick=%0b at cycle %0d", en, big_tick, cyc);
      end else begin
        e = sb.pop_front();
        if (big_tick !== e.big || en !== !e.big || cyc != e.cyc || int'(duty) != e.duty ||
            grip_state !== e.st || int'(envelope) != e.env) begin
          fails++;
          $display("FAIL pulse: got big=%0b en=%0b cyc=%0d duty=%0d st=%0d env=%0d expected big=%0b cyc=%0d duty=%0d st=%0d env=%0d",
                   big_tick, en, cyc, duty, grip_state, envelope, e.big, e.cyc, e.duty, e.st, e.env);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    reset = 0;
    sample_valid = 1;
    sample = 12'd2048;
    repeat (3) @(negedge clk);
    check("rst_duty", int'(duty), 50000);
    check("rst_state", int'(grip_state), 0);
    check("rst_env", int'(envelope), 0);
    check("rst_en", int'(en), 0);
    check("rst_big", int'(big_tick), 0);
    push(1, 199, 50000, S_OPEN, 0);
    push(0, 299, 50000, S_OPEN, 997);
    push(0, 399, 50000, S_OPEN, 997);
    push(0, 499, 50000, S_CLOSING, 997);
    push(0, 599, 70000, S_CLOSING, 997);
    push(0, 699, 90000, S_CLOSING, 997);
    push(0, 799, 100000, S_CLOSED, 997);
    push(0, 899, 100000, S_CLOSED, 0);
    push(0, 999, 100000, S_CLOSED, 0);
    push(0, 1099, 100000, S_OPENING, 0);
    push(0, 1199, 80000, S_OPENING, 0);
    push(0, 1299, 60000, S_OPENING, 0);
    push(0, 1399, 50000, S_OPEN, 0);
    push(0, 1499, 50000, S_OPEN, 997);
    push(0, 1599, 50000, S_OPEN, 300);
    push(0, 1699, 50000, S_OPEN, 300);
    push(0, 1799, 50000, S_OPEN, 997);
    push(0, 1899, 50000, S_OPEN, 300);
    push(0, 1999, 50000, S_OPEN, 300);
    push(0, 2099, 50000, S_OPEN, 997);
    push(0, 2199, 50000, S_OPEN, 997);
    push(0, 2299, 50000, S_CLOSING, 997);
    push(0, 2399, 70000, S_CLOSING, 997);
    reset = 1;
    at_cycle(201); sample = 12'd3048;
    at_cycle(202); check("env_rise1", int'(envelope), 250);
    at_cycle(203); check("env_rise2", int'(envelope), 437);
    at_cycle(801);  sample = 12'd2048;
    at_cycle(1401); sample = 12'd3048;
    at_cycle(1501); sample = 12'd2348;
    at_cycle(1701); sample = 12'd3048;
    at_cycle(1801); sample = 12'd2348;
    at_cycle(2001); sample = 12'd3048;
    at_cycle(2450);
    reset = 0;
    #1;
    check("mid_rst_duty", int'(duty), 50000);
    check("mid_rst_state", int'(grip_state), 0);
    check("mid_rst_env", int'(envelope), 0);
    check("mid_rst_en", int'(en), 0);
    check("mid_rst_big", int'(big_tick), 0);
    check("sb_drain1", sb.size(), 0);
    sample = 12'd2048;
    push(1, 199, 50000, S_OPEN, 0);
    push(0, 299, 50000, S_OPEN, 0);
    repeat (2) @(negedge clk);
    reset = 1;
    at_cycle(350);
    check("sb_drain2", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
